// File: rtl/memory_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : memory_controller_if                                            |
// | Brief    : Core-side request ports and memory-side bus of the controller.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface memory_controller_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  fetchReq;
    logic [ADDR_WIDTH-1:0] fetchAddr;
    logic                  fetchDone;
    logic [DATA_WIDTH-1:0] fetchData;
    logic                  dataReq;
    logic                  dataWrite;
    logic [ADDR_WIDTH-1:0] dataAddr;
    logic [DATA_WIDTH-1:0] dataWData;
    logic                  dataDone;
    logic [DATA_WIDTH-1:0] dataRData;
    logic                  busy;
    logic                  memEnable;
    logic                  memWriteEnable;
    logic [ADDR_WIDTH-1:0] memAddress;
    logic [DATA_WIDTH-1:0] memWriteData;
    logic [DATA_WIDTH-1:0] memReadData;

    modport slave (
        input  fetchReq, fetchAddr, dataReq, dataWrite, dataAddr, dataWData, memReadData,
        output fetchDone, fetchData, dataDone, dataRData, busy,
               memEnable, memWriteEnable, memAddress, memWriteData
    );

    modport master (
        output fetchReq, fetchAddr, dataReq, dataWrite, dataAddr, dataWData, memReadData,
        input  fetchDone, fetchData, dataDone, dataRData, busy,
               memEnable, memWriteEnable, memAddress, memWriteData
    );
endinterface
`default_nettype wire

// File: rtl/memory_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : memory_controller                                               |
// | Brief    : Arbitrates fetch and load/store ports onto a single-port        |
// |            synchronous memory; one access per four cycles.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module memory_controller #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  wire logic           clock,
    input  wire logic           reset,
    memory_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic c_GRANT_FETCH = 1'b0;
    localparam logic c_GRANT_DATA  = 1'b1;

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_grant;
    logic                  r_is_write;
    logic                  r_mem_enable;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_fetch_done;
    logic                  r_data_done;
    logic [DATA_WIDTH-1:0] r_fetch_data;
    logic [DATA_WIDTH-1:0] r_data_rdata;
    logic                  r_busy;

    state_t                w_state;
    logic                  w_last_grant;
    logic                  w_grant;
    logic                  w_is_write;
    logic                  w_mem_enable;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_fetch_done;
    logic                  w_data_done;
    logic [DATA_WIDTH-1:0] w_fetch_data;
    logic [DATA_WIDTH-1:0] w_data_rdata;
    logic                  w_busy;
    logic                  w_pick_data;

    // Data wins when alone, or on a conflict when fetch was served last.
    assign w_pick_data = bus.dataReq &&
                         (!bus.fetchReq || (r_last_grant == c_GRANT_FETCH));

    always_comb begin
        w_state      = r_state;
        w_last_grant = r_last_grant;
        w_grant      = r_grant;
        w_is_write   = r_is_write;
        w_mem_enable = r_mem_enable;
        w_mem_we     = r_mem_we;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_fetch_done = r_fetch_done;
        w_data_done  = r_data_done;
        w_fetch_data = r_fetch_data;
        w_data_rdata = r_data_rdata;

        case (r_state)
            S_IDLE: begin
                if (bus.fetchReq || bus.dataReq) begin
                    w_grant      = w_pick_data ? c_GRANT_DATA : c_GRANT_FETCH;
                    w_last_grant = w_grant;
                    w_mem_enable = 1'b1;
                    w_mem_we     = w_pick_data && bus.dataWrite;
                    w_is_write   = w_mem_we;
                    w_mem_addr   = w_pick_data ? bus.dataAddr : bus.fetchAddr;
                    // Fetches never write, so the write-data bus keeps its last value.
                    if (w_pick_data) begin
                        w_mem_wdata = bus.dataWData;
                    end
                    w_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_mem_enable = 1'b0;
                w_mem_we     = 1'b0;
                w_state      = S_WAIT;
            end
            S_WAIT: begin
                if (r_grant == c_GRANT_DATA) begin
                    if (!r_is_write) begin
                        w_data_rdata = bus.memReadData;
                    end
                    w_data_done = 1'b1;
                end else begin
                    w_fetch_data = bus.memReadData;
                    w_fetch_done = 1'b1;
                end
                w_state = S_DONE;
            end
            S_DONE: begin
                w_fetch_done = 1'b0;
                w_data_done  = 1'b0;
                w_state      = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= c_GRANT_FETCH;
            r_grant      <= c_GRANT_FETCH;
            r_is_write   <= 1'b0;
            r_mem_enable <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_fetch_done <= 1'b0;
            r_data_done  <= 1'b0;
            r_fetch_data <= '0;
            r_data_rdata <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_last_grant <= w_last_grant;
            r_grant      <= w_grant;
            r_is_write   <= w_is_write;
            r_mem_enable <= w_mem_enable;
            r_mem_we     <= w_mem_we;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
            r_fetch_done <= w_fetch_done;
            r_data_done  <= w_data_done;
            r_fetch_data <= w_fetch_data;
            r_data_rdata <= w_data_rdata;
            r_busy       <= w_busy;
        end
    end

    assign bus.memEnable      = r_mem_enable;
    assign bus.memWriteEnable = r_mem_we;
    assign bus.memAddress     = r_mem_addr;
    assign bus.memWriteData   = r_mem_wdata;
    assign bus.fetchDone      = r_fetch_done;
    assign bus.fetchData      = r_fetch_data;
    assign bus.dataDone       = r_data_done;
    assign bus.dataRData      = r_data_rdata;
    assign bus.busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_memory_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_memory_controller                                            |
// | Brief    : Scoreboard bench for memory_controller with a 64K x 16 memory.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_memory_controller;

    localparam int AW = 16;
    localparam int DW = 16;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    memory_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    memory_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Single-port synchronous memory, one-cycle read latency, no reset.
    logic [DW-1:0] mem [0:65535];
    always @(posedge clock) begin
        if (bus.memEnable) begin
            if (bus.memWriteEnable) mem[bus.memAddress] <= bus.memWriteData;
            bus.memReadData <= mem[bus.memAddress];
        end
    end

    typedef struct packed {
        logic          is_data;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && (bus.fetchDone || bus.dataDone)) begin
            if (sb.size() == 0) begin
                check_value("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_value("done_port", {31'd0, bus.dataDone}, {31'd0, mon_e.is_data});
                check_value("done_both", {31'd0, bus.fetchDone & bus.dataDone}, 32'd0);
                if (mon_e.is_data) check_value("dataRData", {16'd0, bus.dataRData}, {16'd0, mon_e.data});
                else               check_value("fetchData", {16'd0, bus.fetchData}, {16'd0, mon_e.data});
            end
        end
    end

    task automatic run_access(input string tag, input logic is_data, input logic wr,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [DW-1:0] exp_data);
        int lat    = 0;
        int en_cnt = 0;
        bit seen   = 1'b0;
        sb.push_back(exp_t'{is_data: is_data, data: exp_data});
        if (is_data) begin
            bus.dataReq   = 1'b1;
            bus.dataWrite = wr;
            bus.dataAddr  = addr;
            bus.dataWData = wdata;
        end else begin
            bus.fetchReq  = 1'b1;
            bus.fetchAddr = addr;
        end
        while (!seen && lat < 12) begin
            @(negedge clock);
            lat++;
            check_value({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            if (bus.memEnable) begin
                en_cnt++;
                check_value({tag, "_memAddress"}, {16'd0, bus.memAddress}, {16'd0, addr});
                check_value({tag, "_memWriteEnable"}, {31'd0, bus.memWriteEnable}, {31'd0, wr});
                if (wr) check_value({tag, "_memWriteData"}, {16'd0, bus.memWriteData}, {16'd0, wdata});
            end
            if (is_data ? bus.dataDone : bus.fetchDone) seen = 1'b1;
        end
        check_value({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check_value({tag, "_latency"}, lat, 32'd3);
        check_value({tag, "_enable_cycles"}, en_cnt, 32'd1);
        bus.fetchReq = 1'b0;
        bus.dataReq  = 1'b0;
        @(negedge clock);
        check_value({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
        check_value({tag, "_done_cleared"}, {30'd0, bus.fetchDone, bus.dataDone}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_done [4];
        int n_done;
        int cyc;

        mem[16'h0010] = 16'hBEEF;
        mem[16'h0100] = 16'hAAAA;
        mem[16'h0200] = 16'h5555;
        mem[16'hFFFF] = 16'hCAFE;
        mem[16'h0000] = 16'h0F0F;
        mem[16'h0020] = 16'h7777;

        // Reset held for two cycles with both requests already active.
        reset         = 1'b1;
        bus.fetchReq  = 1'b1;
        bus.fetchAddr = 16'h0100;
        bus.dataReq   = 1'b1;
        bus.dataWrite = 1'b0;
        bus.dataAddr  = 16'h0200;
        bus.dataWData = 16'h0000;
        repeat (2) @(negedge clock);
        check_value("rst_memEnable", {31'd0, bus.memEnable}, 32'd0);
        check_value("rst_memWriteEnable", {31'd0, bus.memWriteEnable}, 32'd0);
        check_value("rst_memAddress", {16'd0, bus.memAddress}, 32'd0);
        check_value("rst_memWriteData", {16'd0, bus.memWriteData}, 32'd0);
        check_value("rst_fetchDone", {31'd0, bus.fetchDone}, 32'd0);
        check_value("rst_dataDone", {31'd0, bus.dataDone}, 32'd0);
        check_value("rst_fetchData", {16'd0, bus.fetchData}, 32'd0);
        check_value("rst_dataRData", {16'd0, bus.dataRData}, 32'd0);
        check_value("rst_busy", {31'd0, bus.busy}, 32'd0);

        // Continuous conflict: data first, then strict alternation every 4 cycles.
        sb.push_back(exp_t'{is_data: 1'b1, data: 16'h5555});
        sb.push_back(exp_t'{is_data: 1'b0, data: 16'hAAAA});
        sb.push_back(exp_t'{is_data: 1'b1, data: 16'h5555});
        sb.push_back(exp_t'{is_data: 1'b0, data: 16'hAAAA});
        reset  = 1'b0;
        n_done = 0;
        cyc    = 0;
        while (n_done < 4 && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (bus.fetchDone || bus.dataDone) begin
                t_done[n_done] = cyc;
                n_done++;
                if (n_done == 4) begin
                    bus.fetchReq = 1'b0;
                    bus.dataReq  = 1'b0;
                end
            end
        end
        check_value("conflict_done_count", n_done, 32'd4);
        check_value("conflict_first_latency", t_done[0], 32'd3);
        for (int i = 1; i < 4; i++) begin
            check_value("conflict_gap", t_done[i] - t_done[i-1], 32'd4);
        end
        bus.fetchReq = 1'b0;
        bus.dataReq  = 1'b0;
        @(negedge clock);
        check_value("conflict_idle_busy", {31'd0, bus.busy}, 32'd0);

        run_access("fetch", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        // A store leaves the load register at its previous value.
        run_access("store", 1'b1, 1'b1, 16'h8000, 16'h1234, 16'h5555);
        run_access("load", 1'b1, 1'b0, 16'h8000, 16'h0000, 16'h1234);

        run_access("wrap_load", 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hCAFE);
        run_access("wrap_fetch", 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0F0F);
        check_value("wrap_dataRData_kept", {16'd0, bus.dataRData}, 32'h0000CAFE);
        check_value("wrap_fetchData", {16'd0, bus.fetchData}, 32'h00000F0F);

        // Reset during WAIT of a load abandons it silently.
        bus.dataReq   = 1'b1;
        bus.dataWrite = 1'b0;
        bus.dataAddr  = 16'h0020;
        @(negedge clock);
        check_value("midrst_access_enable", {31'd0, bus.memEnable}, 32'd1);
        @(negedge clock);
        check_value("midrst_wait_enable", {31'd0, bus.memEnable}, 32'd0);
        reset       = 1'b1;
        bus.dataReq = 1'b0;
        @(negedge clock);
        check_value("midrst_dataDone", {31'd0, bus.dataDone}, 32'd0);
        check_value("midrst_dataRData", {16'd0, bus.dataRData}, 32'd0);
        check_value("midrst_fetchData", {16'd0, bus.fetchData}, 32'd0);
        check_value("midrst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_value("midrst_no_done", {30'd0, bus.fetchDone, bus.dataDone}, 32'd0);
        end
        run_access("after_rst_load", 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h7777);

        check_value("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
